// File: rtl/cskipa_pipe_adder_if.sv
// Operand/result bus of the pipelined carry-skip adder.
//
// Handshake: both channels use strict valid/ready semantics. A word moves
// on a rising clock edge where valid and ready are both high. Once the
// producer raises valid, it holds valid and the data stable until that edge.
// The consumer may change ready freely. On the input side, in_ready is a
// combinational function of out_valid/out_ready; there is no skid buffer.
interface cskipa_pipe_adder_if #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
);
    localparam int NBLK = (BLK > 0) ? (WIDTH / BLK) : 1;
    localparam int CW   = $clog2(NBLK + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] i_add_term1;
    logic [WIDTH-1:0] i_add_term2;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [CW-1:0]    skip_cnt;

    // Operand producer / result consumer side.
    modport master (
        output in_valid, i_add_term1, i_add_term2, cin, out_ready,
        input  in_ready, out_valid, sum, cout, skip_cnt
    );

    // Adder side.
    modport slave (
        input  in_valid, i_add_term1, i_add_term2, cin, out_ready,
        output in_ready, out_valid, sum, cout, skip_cnt
    );
endinterface

// File: rtl/cskipa_pipe_adder.sv
// Pipelined carry-skip adder.
//
// The operands are split into NBLK = WIDTH/BLK blocks. Pipeline stage k
// resolves block k. It runs a BLK-bit ripple adder on that block and picks
// the outgoing carry with the skip mux: when every bit of the block
// propagates, the incoming carry passes straight through; otherwise the
// ripple carry is used. Both paths give the same value, so the carry-out
// equals a plain ripple add.
//
// Each stage register holds:
//   - valid
//   - the carry into the next block
//   - the settled low sum bits
//   - the operand bits not yet consumed
//   - a running count of skipped blocks
// Each stage stores only the sum bits that are settled and the operand bits
// that are still pending, so no register bit is dead.
//
// Flow control uses one global enable: the pipe advances unless a result
// is being held at the output. Bubbles are kept in place, not collapsed.
module cskipa_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    cskipa_pipe_adder_if.slave bus
);
    localparam int NBLK = (BLK > 0) ? (WIDTH / BLK) : 1;
    localparam int CW   = $clog2(NBLK + 1);

    if (BLK < 1) begin : g_bad_blk
        $error("cskipa_pipe_adder: BLK must be >= 1");
    end else if (WIDTH % BLK != 0) begin : g_bad_width
        $error("cskipa_pipe_adder: WIDTH must be a multiple of BLK");
    end

    // Global advance: the pipe moves unless the output holds an unaccepted result.
    logic en;
    assign en          = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = en;

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        localparam int LO = k * BLK;          // first bit of this block
        localparam int IW = WIDTH - LO;       // operand bits entering this stage
        localparam int SW = LO + BLK;         // sum bits settled after this stage
        localparam int RW = WIDTH - SW;       // operand bits still pending after this stage

        logic            v_in;
        logic            c_in;
        logic [IW-1:0]   a_in;
        logic [IW-1:0]   b_in;
        logic [CW-1:0]   n_in;
        logic [BLK-1:0]  a_blk;
        logic [BLK-1:0]  b_blk;
        logic [BLK-1:0]  s_blk;
        logic            r_blk;
        logic            p_blk;
        logic            c_nx;
        logic [CW-1:0]   n_nx;
        logic [SW-1:0]   s_nx;

        logic            v_q;
        logic            c_q;
        logic [SW-1:0]   s_q;
        logic [CW-1:0]   n_q;

        if (k == 0) begin : g_head
            assign v_in = bus.in_valid;
            assign c_in = bus.cin;
            assign a_in = bus.i_add_term1;
            assign b_in = bus.i_add_term2;
            assign n_in = '0;
            assign s_nx = s_blk;
        end else begin : g_body
            assign v_in = g_stg[k-1].v_q;
            assign c_in = g_stg[k-1].c_q;
            assign a_in = g_stg[k-1].g_ops.a_q;
            assign b_in = g_stg[k-1].g_ops.b_q;
            assign n_in = g_stg[k-1].n_q;
            assign s_nx = {s_blk, g_stg[k-1].s_q};
        end

        assign a_blk = a_in[BLK-1:0];
        assign b_blk = b_in[BLK-1:0];

        // Ripple full-adder chain across the block; sum bits always come from here.
        always_comb begin : ripple
            logic cy;
            cy    = c_in;
            s_blk = '0;
            for (int i = 0; i < BLK; i++) begin
                s_blk[i] = a_blk[i] ^ b_blk[i] ^ cy;
                cy       = (a_blk[i] & b_blk[i]) | (cy & (a_blk[i] ^ b_blk[i]));
            end
            r_blk = cy;
        end

        // Skip mux: a fully propagating block forwards its incoming carry.
        assign p_blk = &(a_blk ^ b_blk);
        assign c_nx  = p_blk ? c_in : r_blk;
        assign n_nx  = n_in + CW'(p_blk);

        // Valid bit follows its predecessor whenever the pipe advances (bubbles included).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
            end else if (en) begin
                v_q <= v_in;
            end
        end

        // Payload only loads for a valid word, so the output keeps its last result behind bubbles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                c_q <= 1'b0;
                s_q <= '0;
                n_q <= '0;
            end else if (en && v_in) begin
                c_q <= c_nx;
                s_q <= s_nx;
                n_q <= n_nx;
            end
        end

        if (RW > 0) begin : g_ops
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;

            // Carry the not-yet-added operand bits down to the stages that consume them.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en && v_in) begin
                    a_q <= a_in[IW-1:BLK];
                    b_q <= b_in[IW-1:BLK];
                end
            end
        end
    end

    assign bus.out_valid = g_stg[NBLK-1].v_q;
    assign bus.sum       = g_stg[NBLK-1].s_q;
    assign bus.cout      = g_stg[NBLK-1].c_q;
    assign bus.skip_cnt  = g_stg[NBLK-1].n_q;
endmodule

// File: tb/tb_cskipa_pipe_adder.sv
// Bench for cskipa_pipe_adder: directed table and corner sequences on a
// 16/4 instance, then random traffic on 16/4, 32/8, 8/1 and 12/12 instances.
module tb_cskipa_pipe_adder;
    localparam int W  = 16;
    localparam int BK = 4;
    localparam int NB = W / BK;
    localparam int CW = $clog2(NB + 1);
    localparam int EW = W + CW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit rand_go = 1'b0;

    // ---------------- directed DUT ----------------
    cskipa_pipe_adder_if #(.WIDTH(W), .BLK(BK)) bus0();
    cskipa_pipe_adder #(.WIDTH(W), .BLK(BK)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    logic [EW-1:0] exp_q[$];
    int            out_cyc[$];
    logic [EW-1:0] mon_e;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          cin;
        logic [W-1:0]  sum;
        logic          cout;
        logic [CW-1:0] skip;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [EW-1:0] model16(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic c);
        logic [W:0]    full;
        logic [W-1:0]  x;
        logic [CW-1:0] n;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        x = a ^ b;
        n = '0;
        for (int k = 0; k < NB; k++) if (&x[k*BK +: BK]) n = n + CW'(1);
        return {full[W], n, full[W-1:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard (directed) ----------------
    always @(negedge clk) begin
        if (rst_n && bus0.out_valid && bus0.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL d_unexpected_output: got sum=%0h with nothing expected", bus0.sum);
            end else begin
                mon_e = exp_q.pop_front();
                check("d_result", {bus0.cout, bus0.skip_cnt, bus0.sum}, mon_e);
                out_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                            input logic [EW-1:0] e, output int waits);
        bit ok;
        ok = 1'b0;
        waits = -1;
        bus0.i_add_term1 = a;
        bus0.i_add_term2 = b;
        bus0.cin = c;
        bus0.in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus0.in_ready) begin
                exp_q.push_back(e);
                waits = t;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL d_accept_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic drain();
        int t;
        bus0.in_valid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("d_drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- random instances ----------------
    function automatic int cfg_w(input int i);
        case (i)
            0: return 16;
            1: return 32;
            2: return 8;
            default: return 12;
        endcase
    endfunction

    function automatic int cfg_b(input int i);
        case (i)
            0: return 4;
            1: return 8;
            2: return 1;
            default: return 12;
        endcase
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_rnd
        localparam int RWD = cfg_w(gi);
        localparam int RB  = cfg_b(gi);
        localparam int RN  = RWD / RB;
        localparam int RC  = $clog2(RN + 1);
        localparam int RE  = RWD + RC + 1;
        localparam int N_OPS = 2500;

        cskipa_pipe_adder_if #(.WIDTH(RWD), .BLK(RB)) rbus();
        cskipa_pipe_adder #(.WIDTH(RWD), .BLK(RB)) u_rdut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (rbus)
        );

        logic [RE-1:0] exp_q[$];
        logic [RE-1:0] e;
        bit done = 1'b0;

        function automatic logic [RE-1:0] model(input logic [RWD-1:0] a, input logic [RWD-1:0] b,
                                                input logic c);
            logic [RWD:0]   full;
            logic [RWD-1:0] x;
            logic [RC-1:0]  n;
            full = {1'b0, a} + {1'b0, b} + {{RWD{1'b0}}, c};
            x = a ^ b;
            n = '0;
            for (int k = 0; k < RN; k++) if (&x[k*RB +: RB]) n = n + RC'(1);
            return {full[RWD], n, full[RWD-1:0]};
        endfunction

        always @(negedge clk) begin
            if (rst_n && rbus.out_valid && rbus.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_w%0d_b%0d_unexpected: got sum=%0h with nothing expected",
                             RWD, RB, rbus.sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({rbus.cout, rbus.skip_cnt, rbus.sum} !== e) begin
                        n_bad++;
                        $display("FAIL rand_w%0d_b%0d: got cout=%0d skip=%0d sum=%0h expected cout=%0d skip=%0d sum=%0h",
                                 RWD, RB, rbus.cout, rbus.skip_cnt, rbus.sum,
                                 e[RE-1], e[RE-2 -: RC], e[RWD-1:0]);
                    end
                end
            end
        end

        initial begin
            logic [RWD-1:0] a, b;
            logic c;
            int sent, cl, t, mode;
            bit hold;
            rbus.in_valid = 1'b0;
            rbus.i_add_term1 = '0;
            rbus.i_add_term2 = '0;
            rbus.cin = 1'b0;
            rbus.out_ready = 1'b0;
            a = '0;
            b = '0;
            c = 1'b0;
            wait (rand_go);
            @(posedge clk);
            #1;
            sent = 0;
            cl = 0;
            hold = 1'b0;
            while (sent < N_OPS && cl < 20000) begin
                if (!hold) begin
                    mode = $urandom_range(0, 7);
                    a = RWD'($urandom);
                    if (mode == 0) b = ~a;               // every block propagates
                    else if (mode == 1) begin a = '1; b = '0; end
                    else b = RWD'($urandom);
                    c = 1'($urandom_range(0, 1));
                    rbus.i_add_term1 = a;
                    rbus.i_add_term2 = b;
                    rbus.cin = c;
                    rbus.in_valid = ($urandom_range(0, 3) != 0);
                end
                rbus.out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (rbus.in_valid && rbus.in_ready) begin
                    exp_q.push_back(model(a, b, c));
                    sent++;
                    hold = 1'b0;
                end else begin
                    hold = rbus.in_valid;
                end
                @(posedge clk);
                #1;
                cl++;
            end
            rbus.in_valid = 1'b0;
            rbus.out_ready = 1'b1;
            t = 0;
            while (exp_q.size() != 0 && t < 200) begin
                @(posedge clk);
                t++;
            end
            #1;
            n_cmp++;
            if (exp_q.size() != 0 || sent != N_OPS) begin
                n_bad++;
                $display("FAIL rand_w%0d_b%0d_drain: got sent=%0d left=%0d expected sent=%0d left=0",
                         RWD, RB, sent, exp_q.size(), N_OPS);
            end
            done = 1'b1;
        end
    end

    // ---------------- main directed sequence ----------------
    initial begin
        int w, wsum, lat, span, vcnt;
        logic [W-1:0] a, b;
        logic c;
        logic [EW-1:0] e0;

        bus0.in_valid = 1'b0;
        bus0.i_add_term1 = '0;
        bus0.i_add_term2 = '0;
        bus0.cin = 1'b0;
        bus0.out_ready = 1'b1;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3'd3};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 3'd4};
        tbl[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 3'd0};
        tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd0};
        tbl[4] = '{16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 3'd4};
        tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 3'd0};
        tbl[6] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 3'd4};
        tbl[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 3'd2};
        tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 3'd0};
        tbl[9] = '{16'h0FF0, 16'h0010, 1'b1, 16'h1001, 1'b0, 3'd1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_outputs", {bus0.cout, bus0.skip_cnt, bus0.sum}, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", bus0.in_ready, 1);

        // Latency of one operand through the empty pipe
        drive_op(16'hFFFF, 16'h0001, 1'b0, {1'b1, 3'd3, 16'h0000}, w);
        bus0.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus0.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, NB);
        drain();

        // Table of fixed vectors, back to back
        foreach (tbl[i]) begin
            drive_op(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].cout, tbl[i].skip, tbl[i].sum}, w);
        end
        drain();

        // Ten back-to-back operands with the consumer always ready
        out_cyc.delete();
        wsum = 0;
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom);
            b = (i % 3 == 0) ? ~a : W'($urandom);
            c = 1'(i & 1);
            drive_op(a, b, c, model16(a, b, c), w);
            wsum += w;
        end
        drain();
        check("b2b_in_ready_waits", wsum, 0);
        check("b2b_count", out_cyc.size(), 10);
        span = (out_cyc.size() >= 10) ? (out_cyc[9] - out_cyc[0]) : -1;
        check("b2b_consecutive", span, 9);

        // Fill the pipe with the consumer stalled, hold for 6 cycles, then release
        bus0.out_ready = 1'b0;
        e0 = model16(16'h1111, 16'h2222, 1'b1);
        drive_op(16'h1111, 16'h2222, 1'b1, e0, w);
        drive_op(16'hAAAA, 16'h5555, 1'b1, model16(16'hAAAA, 16'h5555, 1'b1), w);
        drive_op(16'h0F00, 16'h0100, 1'b0, model16(16'h0F00, 16'h0100, 1'b0), w);
        drive_op(16'hFFFE, 16'h0003, 1'b0, model16(16'hFFFE, 16'h0003, 1'b0), w);
        bus0.i_add_term1 = 16'h4444;
        bus0.i_add_term2 = 16'h3333;
        bus0.cin = 1'b1;
        bus0.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall_in_ready", bus0.in_ready, 0);
            check("stall_out_valid", bus0.out_valid, 1);
            check("stall_hold", {bus0.cout, bus0.skip_cnt, bus0.sum}, e0);
        end
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b1;
        drive_op(16'h4444, 16'h3333, 1'b1, model16(16'h4444, 16'h3333, 1'b1), w);
        drain();

        // Asynchronous reset in the middle of a stream
        drive_op(16'h0001, 16'h0001, 1'b0, model16(16'h0001, 16'h0001, 1'b0), w);
        drive_op(16'h00F0, 16'h0F00, 1'b1, model16(16'h00F0, 16'h0F00, 1'b1), w);
        drive_op(16'h1000, 16'h2000, 1'b0, model16(16'h1000, 16'h2000, 1'b0), w);
        bus0.in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus0.out_valid, 0);
        check("midrst_outputs", {bus0.cout, bus0.skip_cnt, bus0.sum}, 0);
        exp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus0.out_valid) vcnt++;
        end
        check("midrst_no_stale", vcnt, 0);
        @(posedge clk);
        #1;
        drive_op(16'hFFFF, 16'h0000, 1'b1, {1'b1, 3'd4, 16'h0000}, w);
        drain();

        // Random traffic on all configurations
        rand_go = 1'b1;
        for (int t = 0; t < 60000; t++) begin
            if (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done) break;
            @(posedge clk);
        end
        n_cmp++;
        if (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done)) begin
            n_bad++;
            $display("FAIL rand_timeout: got unfinished random phase expected all done");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
